// File: rtl/pc_gen_pkg.sv
// Shared constants and state encoding for the instruction-fetch PC generator.
package pc_gen_pkg;

    localparam logic RstEnable   = 1'b1;
    localparam logic ChipEnable  = 1'b1;
    localparam logic ChipDisable = 1'b0;

    typedef enum logic {
        BOOT = 1'b0,
        RUN  = 1'b1
    } pc_state_e;

endpackage

// File: rtl/pc_gen.sv
// Program-counter generator: registered pc/ce, one-edge update latency.
// A fetch advances only on ce & rom_ready & ~stall; a blocked branch is buffered, a flush is immediate.
module pc_gen
    import pc_gen_pkg::*;
#(
    parameter int          ADDR_W       = 32,
    parameter int          INST_BYTES   = 4,
    parameter logic [ADDR_W-1:0] RESET_VECTOR = '0,
    parameter int          BOOT_DELAY   = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              stall,
    input  logic              rom_ready,
    input  logic              branch_flag,
    input  logic [ADDR_W-1:0] branch_target,
    input  logic              flush,
    input  logic [ADDR_W-1:0] flush_target,
    output logic [ADDR_W-1:0] pc,
    output logic              ce,
    output logic              fetch_fire,
    output logic              redirect_pending
);

    localparam int                ALIGN_BITS = $clog2(INST_BYTES);
    localparam logic [ADDR_W-1:0] ALIGN_MASK = {ADDR_W{1'b1}} << ALIGN_BITS;
    localparam logic [ADDR_W-1:0] PC_STEP    = ADDR_W'(INST_BYTES);
    localparam logic [3:0]        BOOT_INIT  = 4'(BOOT_DELAY - 1);

    pc_state_e         state_q, state_d;
    logic [3:0]        cnt_q, cnt_d;
    logic [ADDR_W-1:0] pc_q, pc_d;
    logic              ce_q, ce_d;
    logic              pend_vld_q, pend_vld_d;
    logic [ADDR_W-1:0] pend_tgt_q, pend_tgt_d;

    logic [ADDR_W-1:0] branch_tgt_dat;
    logic [ADDR_W-1:0] flush_tgt_dat;

    assign branch_tgt_dat = branch_target & ALIGN_MASK;
    assign flush_tgt_dat  = flush_target & ALIGN_MASK;
    assign fetch_fire     = ce_q & rom_ready & ~stall;

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        pc_d       = pc_q;
        ce_d       = ce_q;
        pend_vld_d = pend_vld_q;
        pend_tgt_d = pend_tgt_q;
        unique case (state_q)
            BOOT: begin
                if (cnt_q == 4'd0) begin
                    state_d = RUN;
                    ce_d    = ChipEnable;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            RUN: begin
                // Branch retargets at the accepting edge, so the fetch at pc (delay slot) completes first.
                if (flush) begin
                    pc_d       = flush_tgt_dat;
                    pend_vld_d = 1'b0;
                end else if (fetch_fire && branch_flag) begin
                    pc_d       = branch_tgt_dat;
                    pend_vld_d = 1'b0;
                end else if (fetch_fire && pend_vld_q) begin
                    pc_d       = pend_tgt_q;
                    pend_vld_d = 1'b0;
                end else if (fetch_fire) begin
                    pc_d = pc_q + PC_STEP;
                end else if (branch_flag) begin
                    pend_vld_d = 1'b1;
                    pend_tgt_d = branch_tgt_dat;
                end
            end
            default: begin
                state_d = BOOT;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst == RstEnable) begin
            state_q    <= BOOT;
            cnt_q      <= BOOT_INIT;
            pc_q       <= RESET_VECTOR;
            ce_q       <= ChipDisable;
            pend_vld_q <= 1'b0;
            pend_tgt_q <= '0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            pc_q       <= pc_d;
            ce_q       <= ce_d;
            pend_vld_q <= pend_vld_d;
            pend_tgt_q <= pend_tgt_d;
        end
    end

    assign pc               = pc_q;
    assign ce               = ce_q;
    assign redirect_pending = pend_vld_q;

endmodule

// File: tb/tb_pc_gen.sv
// Directed-vector bench for pc_gen: a 32-bit boot-ROM instance and an 8-bit wrap/alignment instance.
module tb_pc_gen;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    int vectors     = 0;
    int miscompares = 0;

    // 32-bit instance
    logic        stall = 1'b0, rom_ready = 1'b0, branch_flag = 1'b0, flush = 1'b0;
    logic [31:0] branch_target = '0, flush_target = '0;
    logic [31:0] pc;
    logic        ce, fetch_fire, redirect_pending;

    pc_gen #(.ADDR_W(32), .INST_BYTES(4), .RESET_VECTOR(32'hBFC0_0000), .BOOT_DELAY(1)) dut (
        .clk(clk), .rst(rst), .stall(stall), .rom_ready(rom_ready),
        .branch_flag(branch_flag), .branch_target(branch_target),
        .flush(flush), .flush_target(flush_target),
        .pc(pc), .ce(ce), .fetch_fire(fetch_fire), .redirect_pending(redirect_pending)
    );

    // 8-bit instance
    logic       stall8 = 1'b0, rom_ready8 = 1'b0, branch_flag8 = 1'b0, flush8 = 1'b0;
    logic [7:0] branch_target8 = '0, flush_target8 = '0;
    logic [7:0] pc8;
    logic       ce8, fetch_fire8, redirect_pending8;

    pc_gen #(.ADDR_W(8), .INST_BYTES(4), .RESET_VECTOR(8'hF4), .BOOT_DELAY(3)) dut8 (
        .clk(clk), .rst(rst), .stall(stall8), .rom_ready(rom_ready8),
        .branch_flag(branch_flag8), .branch_target(branch_target8),
        .flush(flush8), .flush_target(flush_target8),
        .pc(pc8), .ce(ce8), .fetch_fire(fetch_fire8), .redirect_pending(redirect_pending8)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        if (obs !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, obs, exp);
        end
    endtask

    // Advance one edge; inputs are driven and outputs sampled 1ns after it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        // Reset
        rst = 1'b1; rom_ready = 1'b1;
        tick(); tick();
        chk("rst_pc", pc, 32'hBFC0_0000);
        chk("rst_ce", 32'(ce), 0);
        chk("rst_pend", 32'(redirect_pending), 0);
        chk("rst_fire", 32'(fetch_fire), 0);

        // Boot: flush is ignored on the boot edge
        rst = 1'b0; flush = 1'b1; flush_target = 32'h0000_0444;
        tick();
        flush = 1'b0;
        chk("boot_ce", 32'(ce), 1);
        chk("boot_pc", pc, 32'hBFC0_0000);
        chk("boot_fire", 32'(fetch_fire), 1);
        tick();
        chk("seq1", pc, 32'hBFC0_0004);
        tick();
        chk("seq2", pc, 32'hBFC0_0008);

        // Stall at 0x100
        flush = 1'b1; flush_target = 32'h0000_0100;
        tick();
        flush = 1'b0;
        chk("flush_100", pc, 32'h0000_0100);
        stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            #0;
            chk("stall_fire", 32'(fetch_fire), 0);
            tick();
            chk("stall_pc", pc, 32'h0000_0100);
            chk("stall_ce", 32'(ce), 1);
        end
        stall = 1'b0;
        tick();
        chk("unstall_pc", pc, 32'h0000_0104);

        // Blocked branch is buffered
        flush = 1'b1; flush_target = 32'h0000_0010;
        tick();
        flush = 1'b0; rom_ready = 1'b0;
        branch_flag = 1'b1; branch_target = 32'h0000_2000;
        tick();
        branch_flag = 1'b0;
        chk("blk_pend", 32'(redirect_pending), 1);
        chk("blk_pc", pc, 32'h0000_0010);
        tick();
        chk("blk_hold", pc, 32'h0000_0010);
        rom_ready = 1'b1;
        tick();
        chk("pend_pc", pc, 32'h0000_2000);
        chk("pend_clr", 32'(redirect_pending), 0);

        // Branch accepted with the fetch; misaligned target
        branch_flag = 1'b1; branch_target = 32'h0000_3003;
        tick();
        branch_flag = 1'b0;
        chk("br_now", pc, 32'h0000_3000);
        tick();
        chk("br_next", pc, 32'h0000_3004);

        // Newer blocked branch overwrites the buffer
        rom_ready = 1'b0; branch_flag = 1'b1; branch_target = 32'h0000_4000;
        tick();
        branch_target = 32'h0000_5000;
        tick();
        branch_flag = 1'b0; rom_ready = 1'b1;
        tick();
        chk("ovr_pc", pc, 32'h0000_5000);

        // Fresh branch at fire beats the pending one
        rom_ready = 1'b0; branch_flag = 1'b1; branch_target = 32'h0000_6000;
        tick();
        rom_ready = 1'b1; branch_target = 32'h0000_7000;
        tick();
        branch_flag = 1'b0;
        chk("new_over_pend", pc, 32'h0000_7000);
        chk("new_over_pend_clr", 32'(redirect_pending), 0);

        // Flush and branch together during stall
        stall = 1'b1; flush = 1'b1; flush_target = 32'h0000_0180;
        branch_flag = 1'b1; branch_target = 32'h0000_2000;
        tick();
        flush = 1'b0; branch_flag = 1'b0;
        chk("fl_br_pc", pc, 32'h0000_0180);
        chk("fl_br_pend", 32'(redirect_pending), 0);
        stall = 1'b0;
        tick();
        chk("fl_br_drop", pc, 32'h0000_0184);

        // Flush clears a pending branch
        rom_ready = 1'b0; branch_flag = 1'b1; branch_target = 32'h0000_8000;
        tick();
        branch_flag = 1'b0; flush = 1'b1; flush_target = 32'h0000_0200;
        tick();
        flush = 1'b0;
        chk("fl_pend_clr", 32'(redirect_pending), 0);
        chk("fl_pend_pc", pc, 32'h0000_0200);

        // Reset while a branch is pending
        branch_flag = 1'b1; branch_target = 32'h0000_9000;
        tick();
        branch_flag = 1'b0;
        chk("pre_rst_pend", 32'(redirect_pending), 1);
        rst = 1'b1; rom_ready = 1'b1;
        tick();
        chk("mid_rst_pend", 32'(redirect_pending), 0);
        chk("mid_rst_ce", 32'(ce), 0);
        chk("mid_rst_pc", pc, 32'hBFC0_0000);
        chk("dut8_rst_pc", 32'(pc8), 32'h0000_00F4);
        chk("dut8_rst_ce", 32'(ce8), 0);
        rst = 1'b0; rom_ready8 = 1'b1;
        tick();
        chk("reboot_ce", 32'(ce), 1);
        chk("reboot_pc", pc, 32'hBFC0_0000);

        // 8-bit instance: boot delay of 3, wrap and alignment
        chk("d8_boot1", 32'(ce8), 0);
        tick();
        chk("d8_boot2", 32'(ce8), 0);
        tick();
        chk("d8_boot3", 32'(ce8), 1);
        chk("d8_pc0", 32'(pc8), 32'h0000_00F4);
        tick();
        chk("d8_pc1", 32'(pc8), 32'h0000_00F8);
        tick();
        chk("d8_pc2", 32'(pc8), 32'h0000_00FC);
        tick();
        chk("d8_wrap", 32'(pc8), 32'h0000_0000);
        branch_flag8 = 1'b1; branch_target8 = 8'h37;
        tick();
        branch_flag8 = 1'b0;
        chk("d8_br_align", 32'(pc8), 32'h0000_0034);
        flush8 = 1'b1; flush_target8 = 8'h4B;
        tick();
        flush8 = 1'b0;
        chk("d8_fl_align", 32'(pc8), 32'h0000_0048);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
